cdc_handshake_tx: RTL and testbench

Source-side sender of a 4-phase req/ack bus-crossing handshake. It accepts a word in the local CLK domain and holds it stable on DATA_OUT. It raises REQ_OUT toward the destination domain and waits for the destination's ACK, which it synchronizes internally. It is the transmit end paired with the destination-side multi-flop data synchronizers already used for control/register crossings.

---
 rtl/cdc_pkg.sv | 19 +
 rtl/cdc_handshake_tx_if.sv | 41 ++++
 rtl/cdc_handshake_tx_ack_sync.sv | 27 ++
 rtl/cdc_handshake_tx.sv | 119 +++++++++++
 tb/tb_cdc_handshake_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_pkg.sv
// Shared types and constants for the cdc_handshake_tx source-side handshake block.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_ACK_HI = 2'b01,
    WAIT_ACK_LO = 2'b10
  } state_e;

  localparam int DROP_CNT_W     = 8;
  localparam int NUM_STAGES_MIN = 1;
  localparam int NUM_STAGES_MAX = 4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Handshake/bus bundle for cdc_handshake_tx; DROP_CNT exists only when
// CDC_HANDSHAKE_TX_DROP_CNT_EN is defined.
interface cdc_handshake_tx_if
  import cdc_pkg::*;
#(
  parameter int BUS_WIDTH = 8
);

  logic [BUS_WIDTH-1:0] DATA_IN;
  logic                 DATA_VALID;
  logic                 ACK_ASYNC;
  logic                 READY;
  logic                 REQ_OUT;
  logic [BUS_WIDTH-1:0] DATA_OUT;
  logic                 DONE;

`ifdef CDC_HANDSHAKE_TX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] DROP_CNT;

  modport master (
    input  DATA_IN, DATA_VALID, ACK_ASYNC,
    output READY, REQ_OUT, DATA_OUT, DONE, DROP_CNT
  );

  modport slave (
    output DATA_IN, DATA_VALID, ACK_ASYNC,
    input  READY, REQ_OUT, DATA_OUT, DONE, DROP_CNT
  );
`else
  modport master (
    input  DATA_IN, DATA_VALID, ACK_ASYNC,
    output READY, REQ_OUT, DATA_OUT, DONE
  );

  modport slave (
    output DATA_IN, DATA_VALID, ACK_ASYNC,
    input  READY, REQ_OUT, DATA_OUT, DONE
  );
`endif

endinterface

// File: rtl/cdc_handshake_tx_ack_sync.sv
// ack_sync: NUM_STAGES-deep single-bit synchronizer, async active-high reset to 0.
module ack_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] sync_r;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_r <= {NUM_STAGES{1'b0}};
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < NUM_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign q = sync_r[NUM_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack crossing; optional drop counter under
// CDC_HANDSHAKE_TX_DROP_CNT_EN.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input logic              CLK,
  input logic              RST,
  cdc_handshake_tx_if.master bus
);

  generate
    if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_stages
      $error("cdc_handshake_tx: NUM_STAGES out of range 1..4");
    end
  endgenerate

  state_e               state_r;
  state_e               next_state_s;
  logic                 req_r;
  logic                 next_req_s;
  logic [BUS_WIDTH-1:0] data_r;
  logic [BUS_WIDTH-1:0] next_data_s;
  logic                 done_r;
  logic                 next_done_s;
  logic                 ack_s;
  logic                 ready_s;

  ack_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .CLK(CLK),
    .RST(RST),
    .d  (bus.ACK_ASYNC),
    .q  (ack_s)
  );

  // A stale synchronized ack in IDLE blocks acceptance until the destination catches up.
  assign ready_s = (state_r == IDLE) && !ack_s;

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      data_r  <= {BUS_WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      req_r   <= next_req_s;
      data_r  <= next_data_s;
      done_r  <= next_done_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    next_state_s = state_r;
    next_req_s   = req_r;
    next_data_s  = data_r;
    next_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.DATA_VALID && ready_s) begin
          next_data_s  = bus.DATA_IN;
          next_req_s   = 1'b1;
          next_state_s = WAIT_ACK_HI;
        end else begin
          next_req_s = 1'b0;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          next_req_s   = 1'b0;
          next_state_s = WAIT_ACK_LO;
        end else begin
          next_req_s = 1'b1;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          next_done_s  = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_ACK_LO;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_req_s   = 1'b0;
      end
    endcase
  end

  assign bus.READY    = ready_s;
  assign bus.REQ_OUT  = req_r;
  assign bus.DATA_OUT = data_r;
  assign bus.DONE     = done_r;

`ifdef CDC_HANDSHAKE_TX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  // Count words offered while the block could not take them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_cnt_r <= {DROP_CNT_W{1'b0}};
    end else if (bus.DATA_VALID && !ready_s) begin
      drop_cnt_r <= sat_inc(drop_cnt_r);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign bus.DROP_CNT = drop_cnt_r;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx (NUM_STAGES=2); extra checks with
// CDC_HANDSHAKE_TX_DROP_CNT_EN defined.
module tb_cdc_handshake_tx;

  logic CLK;
  logic RST;
  int   tests_run;
  int   tests_failed;
  logic [7:0] exp_q[$];

  cdc_handshake_tx_if #(.BUS_WIDTH(8)) bus ();

  cdc_handshake_tx #(
    .NUM_STAGES(2),
    .BUS_WIDTH (8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required finish earlier");
    $fatal(1);
  end

  task automatic do_reset();
    RST = 1'b1;
    bus.DATA_VALID = 1'b0;
    bus.DATA_IN = 8'h00;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic send(input logic [7:0] w);
    exp_q.push_back(w);
    bus.DATA_IN = w;
    bus.DATA_VALID = 1'b1;
  endtask

  // Waits for REQ_OUT to rise, then pops and compares the scoreboard.
  task automatic wait_req();
    logic rdy;
    bit seen;
    logic [7:0] exp;
    seen = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      rdy = bus.READY;
      @(negedge CLK);
      if (bus.REQ_OUT === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL req_rise: REQ_OUT=%b, required 1 within 40 cycles", bus.REQ_OUT);
    end else begin
      tests_run++;
      if (rdy !== 1'b1) begin
        tests_failed++;
        $display("FAIL accept_ready: READY before accept=%b, required 1", rdy);
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard: unexpected REQ with DATA_OUT=%h, required no transfer", bus.DATA_OUT);
      end else begin
        exp = exp_q.pop_front();
        if (bus.DATA_OUT !== exp) begin
          tests_failed++;
          $display("FAIL data_out: DATA_OUT=%h, required %h", bus.DATA_OUT, exp);
        end
      end
    end
  endtask

  // Destination model: ACK 3 cycles after REQ, drop 3 cycles after REQ falls.
  task automatic handshake();
    logic [7:0] held;
    held = bus.DATA_OUT;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.REQ_OUT !== 1'b1 || bus.DATA_OUT !== held) begin
        tests_failed++;
        $display("FAIL req_hold: REQ_OUT=%b DATA_OUT=%h, required 1 %h", bus.REQ_OUT, bus.DATA_OUT, held);
      end
    end
    bus.ACK_ASYNC = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.REQ_OUT !== (k < 3) || bus.DATA_OUT !== held) begin
        tests_failed++;
        $display("FAIL req_fall: cycle %0d REQ_OUT=%b DATA_OUT=%h, required %b %h",
                 k, bus.REQ_OUT, bus.DATA_OUT, (k < 3), held);
      end
    end
    repeat (3) @(negedge CLK);
    bus.ACK_ASYNC = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.DONE !== (k == 3) || bus.READY !== (k == 3) || bus.REQ_OUT !== 1'b0 ||
          bus.DATA_OUT !== held) begin
        tests_failed++;
        $display("FAIL done: cycle %0d DONE=%b READY=%b REQ_OUT=%b DATA_OUT=%h, required %b %b 0 %h",
                 k, bus.DONE, bus.READY, bus.REQ_OUT, bus.DATA_OUT, (k == 3), (k == 3), held);
      end
    end
  endtask

  task automatic test_reset();
    bus.ACK_ASYNC = 1'b0;
    do_reset();
    tests_run++;
    if (bus.REQ_OUT !== 1'b0 || bus.DATA_OUT !== 8'h00 || bus.DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: REQ=%b DATA=%h DONE=%b, required 0 00 0",
               bus.REQ_OUT, bus.DATA_OUT, bus.DONE);
    end
    @(negedge CLK);
    tests_run++;
    if (bus.READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: READY=%b, required 1", bus.READY);
    end
  endtask

  task automatic test_basic();
    send(8'hA5);
    wait_req();
    bus.DATA_VALID = 1'b0;
    handshake();
    @(negedge CLK);
    tests_run++;
    if (bus.READY !== 1'b1 || bus.DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_after_done: READY=%b DONE=%b, required 1 0", bus.READY, bus.DONE);
    end
  endtask

  task automatic test_busy();
    do_reset();
    @(negedge CLK);
    send(8'h3C);
    wait_req();
    bus.DATA_IN = 8'hFF;
    @(negedge CLK);
    bus.DATA_VALID = 1'b0;
    tests_run++;
    if (bus.DATA_OUT !== 8'h3C || bus.REQ_OUT !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_hold: DATA_OUT=%h REQ=%b, required 3c 1", bus.DATA_OUT, bus.REQ_OUT);
    end
`ifdef CDC_HANDSHAKE_TX_DROP_CNT_EN
    tests_run++;
    if (bus.DROP_CNT !== 8'd1) begin
      tests_failed++;
      $display("FAIL busy_drop_cnt: DROP_CNT=%0d, required 1", bus.DROP_CNT);
    end
`endif
    handshake();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.REQ_OUT !== 1'b0 || bus.DATA_OUT !== 8'h3C) begin
        tests_failed++;
        $display("FAIL busy_no_second_req: REQ=%b DATA_OUT=%h, required 0 3c", bus.REQ_OUT, bus.DATA_OUT);
      end
    end
  endtask

  task automatic test_stale_ack();
    bus.ACK_ASYNC = 1'b1;
    do_reset();
    @(negedge CLK);
    tests_run++;
    if (bus.READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL stale_cycle1: READY=%b, required 1", bus.READY);
    end
    @(negedge CLK);
    bus.DATA_IN = 8'h77;
    bus.DATA_VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.READY !== 1'b0 || bus.REQ_OUT !== 1'b0 || bus.DATA_OUT !== 8'h00) begin
        tests_failed++;
        $display("FAIL stale_ignore: READY=%b REQ=%b DATA_OUT=%h, required 0 0 00",
                 bus.READY, bus.REQ_OUT, bus.DATA_OUT);
      end
    end
    bus.DATA_VALID = 1'b0;
    bus.ACK_ASYNC = 1'b0;
`ifdef CDC_HANDSHAKE_TX_DROP_CNT_EN
    tests_run++;
    if (bus.DROP_CNT !== 8'd4) begin
      tests_failed++;
      $display("FAIL stale_drop_cnt: DROP_CNT=%0d, required 4", bus.DROP_CNT);
    end
`endif
    for (int k = 1; k <= 2; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.READY !== (k == 2)) begin
        tests_failed++;
        $display("FAIL stale_release: cycle %0d READY=%b, required %b", k, bus.READY, (k == 2));
      end
    end
    send(8'h5A);
    wait_req();
    bus.DATA_VALID = 1'b0;
    handshake();
  endtask

  task automatic test_reset_mid();
    bit fell;
    bus.ACK_ASYNC = 1'b0;
    do_reset();
    @(negedge CLK);
    send(8'h99);
    wait_req();
    bus.DATA_VALID = 1'b0;
    @(negedge CLK);
    bus.ACK_ASYNC = 1'b1;
    fell = 1'b0;
    for (int i = 0; i < 10 && !fell; i++) begin
      @(negedge CLK);
      if (bus.REQ_OUT === 1'b0) fell = 1'b1;
    end
    tests_run++;
    if (!fell || bus.DATA_OUT !== 8'h99) begin
      tests_failed++;
      $display("FAIL mid_wait_lo: REQ=%b DATA_OUT=%h, required 0 99", bus.REQ_OUT, bus.DATA_OUT);
    end
    #2;
    RST = 1'b1;
    #1;
    tests_run++;
    if (bus.REQ_OUT !== 1'b0 || bus.DATA_OUT !== 8'h00 || bus.DONE !== 1'b0 || bus.READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_async_reset: REQ=%b DATA=%h DONE=%b READY=%b, required 0 00 0 1",
               bus.REQ_OUT, bus.DATA_OUT, bus.DONE, bus.READY);
    end
    bus.ACK_ASYNC = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.READY !== 1'b1 || bus.REQ_OUT !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_after_release: READY=%b REQ=%b, required 1 0", bus.READY, bus.REQ_OUT);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge CLK);
    send(8'h01);
    wait_req();
    send(8'h02);
    handshake();
    wait_req();
    send(8'h03);
    handshake();
    wait_req();
    bus.DATA_VALID = 1'b0;
    handshake();
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      tests_run++;
      if (bus.REQ_OUT !== 1'b0 || bus.DATA_OUT !== 8'h03) begin
        tests_failed++;
        $display("FAIL b2b_extra: REQ=%b DATA_OUT=%h, required 0 03", bus.REQ_OUT, bus.DATA_OUT);
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_queue: %0d words pending, required 0", exp_q.size());
    end
  endtask

`ifdef CDC_HANDSHAKE_TX_DROP_CNT_EN
  task automatic test_saturation();
    bus.ACK_ASYNC = 1'b1;
    do_reset();
    repeat (3) @(negedge CLK);
    tests_run++;
    if (bus.READY !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_ready: READY=%b, required 0", bus.READY);
    end
    bus.DATA_VALID = 1'b1;
    repeat (100) @(negedge CLK);
    tests_run++;
    if (bus.DROP_CNT !== 8'd100) begin
      tests_failed++;
      $display("FAIL sat_count100: DROP_CNT=%0d, required 100", bus.DROP_CNT);
    end
    repeat (200) @(negedge CLK);
    tests_run++;
    if (bus.DROP_CNT !== 8'd255 || bus.REQ_OUT !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_count255: DROP_CNT=%0d REQ=%b, required 255 0", bus.DROP_CNT, bus.REQ_OUT);
    end
    bus.DATA_VALID = 1'b0;
    bus.ACK_ASYNC = 1'b0;
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    RST = 1'b1;
    bus.DATA_IN = 8'h00;
    bus.DATA_VALID = 1'b0;
    bus.ACK_ASYNC = 1'b0;
    test_reset();
    test_basic();
    test_busy();
    test_stale_ack();
    test_reset_mid();
    test_back_to_back();
`ifdef CDC_HANDSHAKE_TX_DROP_CNT_EN
    test_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
